ask_tx: RTL

Packet transmitter for the ASK link. It takes bytes from a host over a valid/ready handshake and drives a single serial line at sample-clock rate. Each packet is a fixed sample-rate preamble, then a symbol-rate syncword, then one or more framed data bytes. The framing matches what `ask_rcv` expects: preamble correlation at sample rate, syncword correlation at symbol rate, and 9-symbol byte frames sent MSB first.

---
 rtl/ask_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ask_tx.sv
// ASK packet transmitter: sample-rate preamble, symbol-rate syncword,
// then 9-symbol byte frames (8 data MSB first + stop), back-to-back.
module ask_tx #(
  parameter int PREAMBLE_WIDTH = 32,
  parameter logic [PREAMBLE_WIDTH-1:0] PREAMBLE = 32'hF0F0F0F0,
  parameter int SYNCWORD_WIDTH = 8,
  parameter logic [SYNCWORD_WIDTH-1:0] SYNCWORD = 8'b11100101,
  parameter int SYMBCLK_PRESCALER = 4,
  parameter logic STOP_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       serialout,
  output logic       busy
);

  localparam int MAXPS = (PREAMBLE_WIDTH > SYNCWORD_WIDTH) ?
                         PREAMBLE_WIDTH : SYNCWORD_WIDTH;
  localparam int MAXW  = (MAXPS > 9) ? MAXPS : 9;
  localparam int CW    = $clog2(MAXW);
  localparam int PIW   = (PREAMBLE_WIDTH > 1) ?
                         $clog2(PREAMBLE_WIDTH) : 1;
  localparam int SIW   = (SYNCWORD_WIDTH > 1) ?
                         $clog2(SYNCWORD_WIDTH) : 1;
  localparam int SCW   = $clog2(SYMBCLK_PRESCALER);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SYNC = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;

  logic [2:0]     state;
  logic [2:0]     state_nx;
  logic [7:0]     hold;
  logic [7:0]     shift;
  logic           hold_full;
  logic [SCW-1:0] scnt;
  logic [CW-1:0]  bitcnt;
  logic [PIW-1:0] pidx;
  logic [SIW-1:0] sidx;
  logic           accept;
  logic           sym_end;
  logic           bit_last;
  logic           load;
  logic           bypass;
  logic           level;

  assign ready    = ~hold_full;
  assign busy     = (state != S_IDLE);
  assign accept   = valid & ready;
  assign sym_end  = (scnt == SCW'(SYMBCLK_PRESCALER - 1));
  assign bit_last = (bitcnt == '0);
  assign pidx     = bitcnt[PIW-1:0];
  assign sidx     = bitcnt[SIW-1:0];

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    bypass   = 1'b0;
    level    = 1'b0;
    case (state)
      S_IDLE: begin
        if (hold_full) state_nx = S_PRE;
      end
      S_PRE: begin
        level = PREAMBLE[pidx];
        if (bit_last) state_nx = S_SYNC;
      end
      S_SYNC: begin
        level = SYNCWORD[sidx];
        if (sym_end && bit_last) begin
          state_nx = S_DATA;
          load     = 1'b1;
        end
      end
      S_DATA: begin
        level = shift[7];
        if (sym_end && bit_last) state_nx = S_STOP;
      end
      S_STOP: begin
        level = STOP_LEVEL;
        if (sym_end) begin
          // a byte arriving on this very edge goes straight to shift
          if (hold_full || accept) begin
            state_nx = S_DATA;
            load     = 1'b1;
            bypass   = ~hold_full;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      serialout <= 1'b0;
      hold_full <= 1'b0;
      hold      <= '0;
      shift     <= '0;
    end else begin
      state     <= state_nx;
      serialout <= level;
      if (load) hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;
      if (accept) hold <= data;
      if (load) shift <= bypass ? data : hold;
      else if (state == S_DATA && sym_end)
        shift <= {shift[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt   <= '0;
      bitcnt <= '0;
    end else if (state_nx != state) begin
      scnt <= '0;
      case (state_nx)
        S_PRE:   bitcnt <= CW'(PREAMBLE_WIDTH - 1);
        S_SYNC:  bitcnt <= CW'(SYNCWORD_WIDTH - 1);
        S_DATA:  bitcnt <= CW'(7);
        default: bitcnt <= '0;
      endcase
    end else if (state == S_PRE) begin
      bitcnt <= bitcnt - CW'(1);
    end else if (state != S_IDLE) begin
      if (sym_end) begin
        scnt   <= '0;
        bitcnt <= bitcnt - CW'(1);
      end else begin
        scnt <= scnt + SCW'(1);
      end
    end
  end

endmodule
